// File: rtl/fmq_pkg.sv
// Shared definitions for the host-side phased-array command encoder:
// op codes, controller states and the 3-byte frame packer.
package fmq_pkg;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_RELOAD = 2'b01;
  localparam logic [1:0] OP_QUERY  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam int HDR_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    TX0,
    TX1,
    TX2,
    RESP,
    DONE
  } state_t;

  // Only set frames carry a channel and offset; every other op sends zeros there.
  function automatic logic [23:0] frame_pack(input logic [1:0]  op,
                                             input logic [7:0]  chan,
                                             input logic [10:0] offset);
    logic [7:0]  c;
    logic [10:0] o;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    c  = (op == OP_SET) ? chan   : 8'd0;
    o  = (op == OP_SET) ? offset : 11'd0;
    b0 = {1'b0, op, c[7:3]};
    b0[HDR_BIT] = 1'b1;
    b1 = {1'b0, c[2:0], o[10:7]};
    b2 = {1'b0, o[6:0]};
    return {b0, b1, b2};
  endfunction

endpackage

// File: rtl/fmq_byte_sender.sv
// Three-byte shift register that presents a packed frame, most significant
// byte first, on an AXI-stream valid/ready output.
module fmq_byte_sender (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] frame,
  output logic        busy,
  output logic        byte_acc,
  output logic        last_acc,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready
);

  logic [23:0] shreg;
  logic [1:0]  left;

  // A new frame may be loaded in the same cycle the previous last byte is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= 24'd0;
      left  <= 2'd0;
    end else if (start) begin
      shreg <= frame;
      left  <= 2'd3;
    end else if (byte_acc) begin
      shreg <= {shreg[15:0], 8'h00};
      left  <= left - 2'd1;
    end
  end

  assign m_tvalid = (left != 2'd0);
  assign m_tdata  = shreg[23:16];
  assign byte_acc = m_tvalid & m_tready;
  assign last_acc = byte_acc & (left == 2'd1);
  assign busy     = m_tvalid;

endmodule

// File: rtl/fmq_cmd_encoder.sv
// Serializes host commands and table sweeps into the 3-byte framed command
// stream, and captures the single-byte reply to query frames.
module fmq_cmd_encoder
  import fmq_pkg::*;
#(
  parameter int OUTPUTS      = 64,
  parameter int OFFSET_WIDTH = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int RESP_TIMEOUT = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [7:0]              cmd_chan,
  input  logic [OFFSET_WIDTH-1:0] cmd_offset,
  input  logic                    sweep_start,
  output logic                    sweep_busy,
  output logic                    sweep_done,
  output logic [7:0]              tbl_addr,
  output logic                    tbl_rd,
  input  logic [OFFSET_WIDTH-1:0] tbl_data,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_valid,
  output logic                    resp_timeout
);

  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(RESP_TIMEOUT - 1);

  state_t        state;
  state_t        next_state;
  logic [8:0]    ch;
  logic [8:0]    ch_next;
  logic          sweep_active;
  logic [1:0]    cur_op;
  logic [TW-1:0] tcnt;
  logic          snd_start;
  logic [23:0]   snd_frame;
  logic [1:0]    snd_op;
  logic          snd_busy;
  logic          byte_acc;
  logic          last_acc;
  logic          resp_hit;

  fmq_byte_sender u_sender (
    .clk      (clk),
    .rst      (rst),
    .start    (snd_start),
    .frame    (snd_frame),
    .busy     (snd_busy),
    .byte_acc (byte_acc),
    .last_acc (last_acc),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  // 9-bit channel index so the end-of-sweep compare works for 256 outputs.
  assign ch_next    = ch + 9'd1;
  assign tbl_addr   = ch[7:0];
  assign sweep_busy = sweep_active;
  assign s_tready   = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    snd_start    = 1'b0;
    snd_op       = OP_RELOAD;
    snd_frame    = frame_pack(OP_RELOAD, 8'd0, 11'd0);
    cmd_ready    = 1'b0;
    tbl_rd       = 1'b0;
    resp_timeout = 1'b0;
    sweep_done   = 1'b0;
    resp_hit     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !sweep_start && !rst && !snd_busy;
        if (sweep_start) begin
          next_state = RD;
        end else if (cmd_valid) begin
          snd_start  = 1'b1;
          snd_op     = cmd_op;
          snd_frame  = frame_pack(cmd_op, cmd_chan, cmd_offset);
          next_state = TX0;
        end
      end
      RD: begin
        tbl_rd     = 1'b1;
        next_state = RDW;
      end
      RDW: begin
        snd_start  = 1'b1;
        snd_op     = OP_SET;
        snd_frame  = frame_pack(OP_SET, ch[7:0], tbl_data);
        next_state = TX0;
      end
      TX0: if (byte_acc) next_state = TX1;
      TX1: if (byte_acc) next_state = TX2;
      TX2: begin
        if (last_acc) begin
          if (sweep_active && cur_op == OP_SET) begin
            if (ch_next == 9'(OUTPUTS)) begin
              snd_start  = 1'b1;
              next_state = TX0;
            end else begin
              next_state = RD;
            end
          end else if (sweep_active) begin
            next_state = DONE;
          end else if (cur_op[1]) begin
            next_state = RESP;
          end else begin
            next_state = IDLE;
          end
        end
      end
      // A reply arriving in the final counted cycle still wins over the timeout.
      RESP: begin
        if (s_tvalid) begin
          resp_hit   = 1'b1;
          next_state = IDLE;
        end else if (tcnt == TO_LAST) begin
          resp_timeout = 1'b1;
          next_state   = IDLE;
        end
      end
      DONE: begin
        sweep_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch           <= 9'd0;
      sweep_active <= 1'b0;
      cur_op       <= OP_SET;
      tcnt         <= '0;
      resp_data    <= '0;
      resp_valid   <= 1'b0;
    end else begin
      resp_valid <= resp_hit;
      if (resp_hit) resp_data <= s_tdata;
      if (snd_start) cur_op <= snd_op;
      tcnt <= (state == RESP) ? tcnt + 1'b1 : '0;
      if (state == IDLE && sweep_start) begin
        sweep_active <= 1'b1;
        ch           <= 9'd0;
      end else if (state == DONE) begin
        sweep_active <= 1'b0;
        ch           <= 9'd0;
      end else if (state == TX2 && last_acc && sweep_active && cur_op == OP_SET) begin
        ch <= ch_next;
      end
    end
  end

endmodule

// File: tb/tb_fmq_cmd_encoder.sv
// Self-checking bench for fmq_cmd_encoder: table vectors, random frames
// against an arithmetic frame model, and hand-written multi-cycle sequences.
module tb_fmq_cmd_encoder;

  localparam int OUTPUTS = 4;
  localparam int RESP_TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_chan;
  logic [10:0] cmd_offset;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [7:0]  tbl_addr;
  logic        tbl_rd;
  logic [10:0] tbl_data;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_timeout;

  fmq_cmd_encoder #(
    .OUTPUTS      (OUTPUTS),
    .OFFSET_WIDTH (11),
    .DATA_WIDTH   (8),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_chan     (cmd_chan),
    .cmd_offset   (cmd_offset),
    .sweep_start  (sweep_start),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .tbl_addr     (tbl_addr),
    .tbl_rd       (tbl_rd),
    .tbl_data     (tbl_data),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .resp_timeout (resp_timeout)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscomp = 0;

  // Reference frame built from the byte layout with plain arithmetic.
  function automatic logic [23:0] model_frame(input int op, input int chan, input int off);
    int c;
    int o;
    c = (op == 0) ? chan : 0;
    o = (op == 0) ? off  : 0;
    return {8'(128 + op * 32 + c / 8), 8'((c % 8) * 16 + o / 128), 8'(o % 128)};
  endfunction

  logic [10:0] tbl_mem [0:255];
  always @(posedge clk) if (tbl_rd) tbl_data <= tbl_mem[tbl_addr];

  int   tr_mode = 0;
  logic tr_manual = 1'b1;
  int   tr_phase = 0;
  initial forever begin
    @(posedge clk);
    #2;
    tr_phase++;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (tr_phase % 3 == 0);
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = tr_manual;
    endcase
  end

  logic [7:0] rx_q[$];
  logic [7:0] addr_q[$];
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   accept_cyc = 0;
  int   to_cyc = 0;
  int   resp_cnt = 0;
  int   to_cnt = 0;
  int   done_cnt = 0;
  int   stall_err = 0;
  int   ready_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (m_tvalid && m_tready) begin
      rx_q.push_back(m_tdata);
      last_acc_cyc = cyc;
    end
    if (prev_stall && (!m_tvalid || m_tdata != prev_data)) stall_err++;
    prev_stall = m_tvalid && !m_tready && !rst;
    prev_data  = m_tdata;
    if (cmd_valid && cmd_ready) accept_cyc = cyc;
    if (cmd_ready && (m_tvalid || sweep_busy)) ready_err++;
    if (resp_valid) resp_cnt++;
    if (resp_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (sweep_done) done_cnt++;
    if (tbl_rd) addr_q.push_back(tbl_addr);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscomp++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] ch,
                                input logic [10:0] off, output bit ok);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_chan = ch;
    cmd_offset = off;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata = b;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_resp(input int c0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_cnt != c0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [23:0] first_frame();
    if (rx_q.size() >= 3) return {rx_q[0], rx_q[1], rx_q[2]};
    return 24'hxxxxxx;
  endfunction

  // One non-query frame: bytes, stall stability, and prompt return to idle.
  task automatic run_frame(input string name, input logic [1:0] op, input logic [7:0] ch,
                           input logic [10:0] off, input int mode, input logic [23:0] exp);
    bit ok;
    int k;
    tr_mode = mode;
    rx_q.delete();
    apply_stimulus(op, ch, off, ok);
    check_output({name, "_accept"}, 32'(ok), 32'd1);
    wait_bytes(3, 300, ok);
    check_output({name, "_bytes"}, 32'(first_frame()), 32'(exp));
    if (mode == 0) check_output({name, "_latency"}, 32'(last_acc_cyc - accept_cyc <= 6), 32'd1);
    k = 0;
    while (!cmd_ready && k < 10) begin
      tick();
      k++;
    end
    check_output({name, "_idle"}, 32'(k <= 2), 32'd1);
    check_output({name, "_count"}, 32'(rx_q.size()), 32'd3);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  chan;
    logic [10:0] off;
    int          mode;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] rst_vec;
  assign rst_vec = {m_tvalid, cmd_ready, sweep_busy, sweep_done, tbl_rd, resp_valid,
                    resp_timeout, s_tready, tbl_addr, resp_data, m_tdata};
  localparam logic [31:0] RST_EXP = {7'b0, 1'b1, 8'h00, 8'h00, 8'h00};

  initial begin
    bit ok;
    int c0;
    int t0;
    int b2;
    logic [7:0] op_r;
    logic [7:0] ch_r;
    logic [10:0] off_r;
    logic [23:0] exp_s [6];

    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int c0;
    int t0;
    int b2;
    logic [1:0]  op_r;
    logic [7:0]  ch_r;
    logic [10:0] off_r;
    logic [23:0] exp_s [6];

    vecs[0] = '{2'b00, 8'd5,   11'h3A7, 0, 24'h805727};
    vecs[1] = '{2'b00, 8'd43,  11'h7FF, 1, 24'h853F7F};
    vecs[2] = '{2'b01, 8'd0,   11'h000, 0, 24'hA00000};
    vecs[3] = '{2'b00, 8'd255, 11'h000, 2, 24'h9F7000};
    vecs[4] = '{2'b00, 8'd0,   11'h07F, 0, 24'h80007F};
    vecs[5] = '{2'b01, 8'hFF,  11'h7FF, 1, 24'hA00000};

    for (int i = 0; i < 256; i++) tbl_mem[i] = 11'd0;
    tbl_mem[0] = 11'h001;
    tbl_mem[1] = 11'h080;
    tbl_mem[2] = 11'h400;
    tbl_mem[3] = 11'h7FF;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_chan = 8'd0;
    cmd_offset = 11'd0;
    sweep_start = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = 8'h00;
    repeat (3) @(posedge clk);
    tick();
    check_output("reset_outputs", rst_vec, RST_EXP);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].op, vecs[i].chan, vecs[i].off,
                vecs[i].mode, vecs[i].exp);

    for (int i = 0; i < 24; i++) begin
      op_r  = 2'($urandom_range(0, 1));
      ch_r  = 8'($urandom_range(0, 255));
      off_r = 11'($urandom_range(0, 2047));
      run_frame($sformatf("rand%0d", i), op_r, ch_r, off_r, 2,
                model_frame(int'(op_r), int'(ch_r), int'(off_r)));
    end

    // Query answered a few cycles after the last header byte.
    tr_mode = 0;
    rx_q.delete();
    c0 = resp_cnt;
    t0 = to_cnt;
    apply_stimulus(2'b10, 8'd9, 11'h123, ok);
    wait_bytes(3, 100, ok);
    check_output("query_bytes", 32'(first_frame()), 32'hC00000);
    repeat (4) @(posedge clk);
    send_rx(8'h40);
    wait_resp(c0, ok);
    check_output("query_resp_seen", 32'(ok), 32'd1);
    tick();
    check_output("query_resp_data", 32'(resp_data), 32'h40);
    check_output("query_resp_pulses", 32'(resp_cnt - c0), 32'd1);
    check_output("query_no_timeout", 32'(to_cnt - t0), 32'd0);

    // Reserved op also waits for a reply.
    rx_q.delete();
    c0 = resp_cnt;
    apply_stimulus(2'b11, 8'd200, 11'h7FF, ok);
    wait_bytes(3, 100, ok);
    check_output("rsvd_bytes", 32'(first_frame()), 32'hE00000);
    send_rx(8'h99);
    wait_resp(c0, ok);
    tick();
    check_output("rsvd_resp_data", 32'(resp_data), 32'h99);

    // Unanswered query times out a fixed number of cycles after the last byte.
    rx_q.delete();
    c0 = resp_cnt;
    t0 = to_cnt;
    apply_stimulus(2'b10, 8'd0, 11'd0, ok);
    wait_bytes(3, 100, ok);
    b2 = last_acc_cyc;
    for (int i = 0; i < 300; i++) begin
      if (to_cnt != t0) break;
      tick();
    end
    check_output("timeout_pulses", 32'(to_cnt - t0), 32'd1);
    check_output("timeout_delay", 32'(to_cyc - b2), 32'(RESP_TIMEOUT));
    check_output("timeout_data_kept", 32'(resp_data), 32'h99);
    send_rx(8'h11);
    repeat (5) tick();
    check_output("idle_rx_ignored", 32'(resp_cnt - c0), 32'd0);
    check_output("idle_rx_data", 32'(resp_data), 32'h99);

    // Sweep requested together with a command; the command must wait.
    for (int i = 0; i < 4; i++) exp_s[i] = model_frame(0, i, int'(tbl_mem[i]));
    exp_s[4] = model_frame(1, 0, 0);
    exp_s[5] = model_frame(0, 7, 5);
    tr_mode = 2;
    rx_q.delete();
    addr_q.delete();
    c0 = done_cnt;
    @(posedge clk);
    #1;
    sweep_start = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_chan = 8'd7;
    cmd_offset = 11'd5;
    tick();
    check_output("sweep_cmd_blocked", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    tick();
    check_output("sweep_busy_set", 32'(sweep_busy), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_output("sweep_finished", 32'(ok), 32'd1);
    check_output("sweep_byte_count", 32'(rx_q.size()), 32'd15);
    check_output("sweep_busy_clear", 32'(sweep_busy), 32'd0);
    check_output("sweep_done_pulses", 32'(done_cnt - c0), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_bytes(18, 300, ok);
    for (int f = 0; f < 6; f++)
      check_output($sformatf("sweep_frame%0d", f),
                   (rx_q.size() >= 3 * f + 3) ? 32'({rx_q[3*f], rx_q[3*f+1], rx_q[3*f+2]}) : 32'hFFFFFFFF,
                   32'(exp_s[f]));
    check_output("sweep_reads", 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("sweep_addr%0d", i),
                   (addr_q.size() > i) ? 32'(addr_q[i]) : 32'hFFFFFFFF, 32'(i));

    // Reset while the second byte of a set frame is stalled.
    repeat (3) tick();
    tr_mode = 3;
    tr_manual = 1'b1;
    rx_q.delete();
    apply_stimulus(2'b00, 8'd5, 11'h3A7, ok);
    wait_bytes(1, 20, ok);
    @(posedge clk);
    #1;
    tr_manual = 1'b0;
    rst = 1'b1;
    tick();
    check_output("midframe_b1", 32'({m_tvalid, m_tdata}), 32'h157);
    @(posedge clk);
    #1;
    tick();
    check_output("midframe_reset", rst_vec, RST_EXP);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tr_mode = 0;
    rx_q.delete();
    c0 = resp_cnt;
    apply_stimulus(2'b10, 8'd0, 11'd0, ok);
    wait_bytes(3, 100, ok);
    check_output("post_reset_query", 32'(first_frame()), 32'hC00000);
    send_rx(8'h5A);
    wait_resp(c0, ok);
    tick();
    check_output("post_reset_resp", 32'(resp_data), 32'h5A);
    check_output("post_reset_count", 32'(rx_q.size()), 32'd3);

    check_output("stall_stability", 32'(stall_err), 32'd0);
    check_output("ready_while_busy", 32'(ready_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscomp);
    $finish;
  end

endmodule

// File: doc/fmq_cmd_encoder.md
Name: fmq_cmd_encoder

Overview:
Host-side counterpart of the phased-array UART command decoder. It accepts high-level commands and serializes each into the 3-byte framed command stream the array FPGA parses. The commands are: set one channel offset, reload, query output count, and the reserved op. It also runs an autonomous sweep that loads every channel offset from an external table and then issues a reload. The byte output feeds a UART transmitter's AXI-stream input. The byte input takes the UART receiver's output and captures query responses.

Parameters:
OUTPUTS, 64, number of transducer channels walked by a sweep (1..256).
OFFSET_WIDTH, 11, phase offset width; fixed by frame format, must be 11.
DATA_WIDTH, 8, stream byte width; must be 8.
RESP_TIMEOUT, 1000000, clk cycles to wait for a query response before giving up.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 set offset, 01 reload, 10 query outputs, 11 reserved
cmd_chan  in  8  channel index (op 00 only)
cmd_offset  in  11  offset value (op 00 only)
sweep_start  in  1  pulse: begin table sweep
sweep_busy  out  1  sweep in progress
sweep_done  out  1  1-cycle pulse after the sweep's reload frame is accepted
tbl_addr  out  8  table read address
tbl_rd  out  1  table read strobe; tbl_data valid exactly 1 cycle later
tbl_data  in  11  table read data
m_tdata  out  8  byte to UART TX
m_tvalid  out  1  byte valid
m_tready  in  1  UART TX ready
s_tdata  in  8  byte from UART RX
s_tvalid  in  1  RX byte valid
s_tready  out  1  always 1 (RX bytes are never back-pressured)
resp_data  out  8  captured response byte
resp_valid  out  1  1-cycle pulse with resp_data
resp_timeout  out  1  1-cycle pulse on query timeout

Behaviour:
- Frame layout for op, chan c, offset o:
  - B0 = {1, op[1:0], c[7:3]}
  - B1 = {0, c[2:0], o[10:7]}
  - B2 = {0, o[6:0]}
  - Sent B0, B1, B2 in order. For ops 01/10/11, c and o are forced to 0.
- Reset: all outputs 0 except s_tready = 1. FSM to IDLE; sweep counter, timeout counter and resp_data cleared.
- FSM states: IDLE, RD (tbl_rd asserted), RDW (capture tbl_data), TX0, TX1, TX2, RESP, DONE.
- IDLE:
  - sweep_start has priority over cmd_valid when both are high in the same cycle.
  - cmd_ready = 1 only in IDLE with sweep_start low.
  - On command acceptance, the frame is latched into a 24-bit register and the FSM goes to TX0 the next cycle.
- TXn: m_tvalid = 1 with byte n.
  - m_tdata is stable while m_tvalid & !m_tready.
  - On m_tready the next byte is presented in the following cycle: one bubble cycle per byte is allowed, max 2 cycles per byte when m_tready is held high.
- After B2 is accepted:
  - op 10 or 11 goes to RESP.
  - A sweep set-frame goes to the next channel.
  - Any other frame goes to IDLE.
- RESP:
  - First s_tvalid byte: resp_data <= s_tdata, resp_valid pulse, go to IDLE.
  - The timeout counter counts cycles in RESP. At RESP_TIMEOUT, pulse resp_timeout and go to IDLE with resp_data unchanged.
  - RX bytes arriving outside RESP are silently discarded.
- Sweep:
  - sweep_busy = 1 from the cycle after sweep_start through DONE.
  - For ch = 0..OUTPUTS-1: tbl_addr = ch, tbl_rd pulse (RD), latch tbl_data (RDW), send a set frame.
  - After the last channel, send the reload frame (A0 00 00), pulse sweep_done, clear sweep_busy, return to IDLE.
  - sweep_start and cmd_valid are ignored while busy.
  - The counter must not wrap when OUTPUTS = 256; use a 9-bit compare.
- cmd_chan >= OUTPUTS is transmitted unchanged; the device ignores it.
- Reset mid-frame:
  - m_tvalid drops in the cycle after rst.
  - A header byte already sent can pair with the next frame's bytes at the device. rst must therefore only be asserted while !m_tvalid, or together with the device reset. This is a system rule; the block does not enforce it.

Decomposition:
- Package fmq_pkg holds:
  - op codes OP_SET = 2'b00, OP_RELOAD = 2'b01, OP_QUERY = 2'b10, OP_RSVD = 2'b11;
  - the FSM state enum;
  - the frame header bit position (7);
  - a function frame_pack(op, chan, offset) returning 24 bits.
- One natural sub-module: fmq_byte_sender, a 3-byte shift register with AXI-stream valid/ready output, start/busy/last-byte signals.

Test Plan:
1. Set chan 5, offset 0x3A7, m_tready = 1 -> bytes 0x80, 0x57, 0x27; cmd_ready low until return to IDLE.
2. Set chan 43, offset 0x7FF, m_tready toggling 1-in-3 -> bytes 0x85, 0x3F, 0x7F; m_tdata stable whenever stalled.
3. Reload -> 0xA0, 0x00, 0x00, then IDLE with no resp wait. Query -> 0xC0, 0x00, 0x00; inject RX 0x40 five cycles later -> resp_valid pulse, resp_data = 0x40.
4. Query with no RX, RESP_TIMEOUT = 100 -> resp_timeout pulse exactly 100 cycles after B2 accepted. An RX byte 0x11 sent while in IDLE produces no resp_valid.
5. OUTPUTS = 4, table {0x001, 0x080, 0x400, 0x7FF}, sweep_start together with cmd_valid -> exactly 15 bytes: 80 00 01, 80 11 00, 80 28 00, 80 3F 7F, A0 00 00. sweep_done pulses once; the cmd is not accepted until IDLE.
6. rst asserted during TX1 of a set frame -> m_tvalid = 0 the next cycle, all outputs at reset values; a following query sends 0xC0 00 00 cleanly.
